if_fetch: RTL and testbench

//   Instruction-fetch stage feeding the decode stage. Owns the PC, issues word

---
 rtl/if_fetch_pkg.sv | 34 +++
 rtl/if_fetch_fifo.sv | 76 +++++++
 rtl/if_fetch.sv | 193 +++++++++++++++++++
 tb/tb_if_fetch.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types, constants and helpers for the instruction-fetch stage.
// Optional branch redirect support is enabled with `define IF_REDIRECT_EN.
package if_fetch_pkg;

   localparam int unsigned INST_ADDR_W = 32;
   localparam int unsigned INST_W      = 32;
   localparam int unsigned FETCH_DEPTH = 2;

   localparam logic [INST_W-1:0] ZERO_WORD = '0;

   typedef logic [INST_ADDR_W-1:0] inst_addr_t;
   typedef logic [INST_W-1:0]      inst_t;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_WAIT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      inst_addr_t pc;
      inst_t      inst;
   } fetch_entry_t;

   // Fetches are word granular, so the low two address bits are always cleared.
   function automatic inst_addr_t word_align(input inst_addr_t addr);
      return addr & ~inst_addr_t'(3);
   endfunction

   function automatic inst_addr_t next_pc(input inst_addr_t pc);
      return pc + inst_addr_t'(4);
   endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO buffering fetched {pc, inst} entries toward decode.
// Flush wins over push/pop; pop on empty is ignored; head is read straight from storage.
module if_fetch_fifo #(
   parameter  int unsigned DEPTH = 2,
   parameter  int unsigned WIDTH = 64,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // A push into a full buffer is only accepted when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches words over req/gnt/rvalid, buffers results for decode.
// `define IF_REDIRECT_EN adds redirect_i/redirect_pc_i with in-flight response discard.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = FETCH_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   output logic        inst_req_o,
   output logic [31:0] inst_addr_o,
   input  logic        inst_gnt_i,
   input  logic        inst_rvalid_i,
   input  logic [31:0] inst_rdata_i,
   output logic        if_valid_o,
   input  logic        if_ready_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o
`ifdef IF_REDIRECT_EN
   ,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
`endif
);

   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam inst_addr_t  RESET_PC_ALIGNED = word_align(RESET_PC);

   fetch_state_e     state_q, state_d;
   inst_addr_t       pc_q, pc_d;
   logic             req_q, req_d;
   inst_addr_t       addr_q, addr_d;

   logic             push;
   logic             pop;
   logic             flush;
   logic             drop_rsp;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W-1:0] count_next;
   logic             slot_free;
   fetch_entry_t     push_entry;
   fetch_entry_t     head_entry;

`ifdef IF_REDIRECT_EN
   logic             discard_q, discard_d;
   inst_addr_t       redirect_pc;

   assign redirect_pc = word_align(redirect_pc_i);
   // Responses are dropped when they belong to a fetch made before a redirect.
   assign drop_rsp    = discard_q | redirect_i;
`else
   assign drop_rsp    = 1'b0;
`endif

   assign pop  = if_ready_i & ~fifo_empty;
   assign push = (state_q == FETCH_WAIT) & inst_rvalid_i & ~drop_rsp & (~fifo_full | pop);

   assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
   assign slot_free  = (count_next < CNT_W'(FIFO_DEPTH));

   assign push_entry.pc   = pc_q;
   assign push_entry.inst = inst_rdata_i;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      req_d   = req_q;
      addr_d  = addr_q;
      flush   = 1'b0;
`ifdef IF_REDIRECT_EN
      discard_d = discard_q;
`endif
      unique case (state_q)
         FETCH_IDLE: begin
            if (slot_free) begin
               state_d = FETCH_REQ;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end
         end
         FETCH_REQ: begin
            if (inst_gnt_i) begin
               state_d = FETCH_WAIT;
               req_d   = 1'b0;
            end
         end
         FETCH_WAIT: begin
            if (inst_rvalid_i) begin
               pc_d = drop_rsp ? pc_q : next_pc(pc_q);
`ifdef IF_REDIRECT_EN
               discard_d = 1'b0;
`endif
               if (slot_free) begin
                  state_d = FETCH_REQ;
                  req_d   = 1'b1;
                  addr_d  = pc_d;
               end else begin
                  state_d = FETCH_IDLE;
                  req_d   = 1'b0;
               end
            end
         end
         default: begin
            state_d = FETCH_IDLE;
            req_d   = 1'b0;
         end
      endcase

`ifdef IF_REDIRECT_EN
      // A redirect overrides sequential fetch; an accepted-but-unanswered request must be discarded.
      if (redirect_i) begin
         flush = 1'b1;
         pc_d  = redirect_pc;
         case (state_q)
            FETCH_REQ: begin
               if (inst_gnt_i) begin
                  state_d   = FETCH_WAIT;
                  req_d     = 1'b0;
                  discard_d = 1'b1;
               end else begin
                  state_d = FETCH_REQ;
                  req_d   = 1'b1;
                  addr_d  = redirect_pc;
               end
            end
            FETCH_WAIT: begin
               if (inst_rvalid_i) begin
                  state_d   = FETCH_REQ;
                  req_d     = 1'b1;
                  addr_d    = redirect_pc;
                  discard_d = 1'b0;
               end else begin
                  state_d   = FETCH_WAIT;
                  req_d     = 1'b0;
                  discard_d = 1'b1;
               end
            end
            default: begin
               state_d = FETCH_REQ;
               req_d   = 1'b1;
               addr_d  = redirect_pc;
            end
         endcase
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH_IDLE;
         pc_q    <= RESET_PC_ALIGNED;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC_ALIGNED;
`ifdef IF_REDIRECT_EN
         discard_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
`ifdef IF_REDIRECT_EN
         discard_q <= discard_d;
`endif
      end
   end

   if_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (push_entry),
      .rdata (head_entry),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign inst_req_o  = req_q;
   assign inst_addr_o = addr_q;
   assign if_valid_o  = ~fifo_empty;
   assign if_pc_o     = head_entry.pc;
   assign if_inst_o   = head_entry.inst;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: a vector table for steady-state fetch plus
// hand-written sequences for buffering, handshake stalls, PC wrap, reset and redirect.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        req0, valid0, gnt0, rv0, ready0;
   logic [31:0] addr0, rdata0, pc0, inst0;

   logic        req1, valid1, gnt1, rv1, ready1;
   logic [31:0] addr1, rdata1, pc1, inst1;

`ifdef IF_REDIRECT_EN
   logic        redir0, redir1;
   logic [31:0] redirPc0, redirPc1;
`endif

   int checkCount = 0;
   int passCount  = 0;

   always #5 clk = ~clk;

   if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut0 (
      .clk(clk), .rst(rst),
      .inst_req_o(req0), .inst_addr_o(addr0), .inst_gnt_i(gnt0),
      .inst_rvalid_i(rv0), .inst_rdata_i(rdata0),
      .if_valid_o(valid0), .if_ready_i(ready0), .if_pc_o(pc0), .if_inst_o(inst0)
`ifdef IF_REDIRECT_EN
      , .redirect_i(redir0), .redirect_pc_i(redirPc0)
`endif
   );

   if_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut1 (
      .clk(clk), .rst(rst),
      .inst_req_o(req1), .inst_addr_o(addr1), .inst_gnt_i(gnt1),
      .inst_rvalid_i(rv1), .inst_rdata_i(rdata1),
      .if_valid_o(valid1), .if_ready_i(ready1), .if_pc_o(pc1), .if_inst_o(inst1)
`ifdef IF_REDIRECT_EN
      , .redirect_i(redir1), .redirect_pc_i(redirPc1)
`endif
   );

   typedef struct {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
      logic        ready;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expValid;
      logic        chkData;
      logic [31:0] expPc;
      logic [31:0] expInst;
   } vec_t;

   vec_t vecs[10];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic applyStimulus(input logic g, input logic rv, input logic [31:0] rd, input logic rdy);
      gnt0   = g;
      rv0    = rv;
      rdata0 = rd;
      ready0 = rdy;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Holds reset for a few cycles, releases it on a falling edge and returns there.
   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      gnt1 = 1'b0; rv1 = 1'b0; rdata1 = 32'h0; ready1 = 1'b0;
`ifdef IF_REDIRECT_EN
      redir0 = 1'b0; redirPc0 = 32'h0; redir1 = 1'b0; redirPc1 = 32'h0;
`endif
      rst = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
   endtask

   initial begin
      logic reqSeen;
      logic pcMoved;

      vecs[0] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'h00, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0};
      vecs[2] = '{1'b1, 1'b1, 32'h1300_0000, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 32'h0};
      vecs[3] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h04, 1'b1, 1'b1, 32'h00, 32'h1300_0000};
      vecs[4] = '{1'b1, 1'b1, 32'h1300_0004, 1'b1, 1'b0, 32'h04, 1'b0, 1'b0, 32'h00, 32'h0};
      vecs[5] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h08, 1'b1, 1'b1, 32'h04, 32'h1300_0004};
      vecs[6] = '{1'b1, 1'b1, 32'h1300_0008, 1'b1, 1'b0, 32'h08, 1'b0, 1'b0, 32'h00, 32'h0};
      vecs[7] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0C, 1'b1, 1'b1, 32'h08, 32'h1300_0008};
      vecs[8] = '{1'b1, 1'b1, 32'h1300_000C, 1'b1, 1'b0, 32'h0C, 1'b0, 1'b0, 32'h00, 32'h0};
      vecs[9] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h0C, 32'h1300_000C};

      $display("[TB] start");
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      gnt1 = 1'b0; rv1 = 1'b0; rdata1 = 32'h0; ready1 = 1'b0;
`ifdef IF_REDIRECT_EN
      redir0 = 1'b0; redirPc0 = 32'h0; redir1 = 1'b0; redirPc1 = 32'h0;
`endif
      tick();
      checkOutput("rst_addr1", addr1, 32'hFFFF_FFF8);
      checkOutput("rst_req1", {31'b0, req1}, 32'h0);

      // Steady-state streaming: immediate grant, 1-cycle ROM, decode always ready.
      doReset();
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("vec%0d_req", i), {31'b0, req0}, {31'b0, vecs[i].expReq});
         checkOutput($sformatf("vec%0d_addr", i), addr0, vecs[i].expAddr);
         checkOutput($sformatf("vec%0d_valid", i), {31'b0, valid0}, {31'b0, vecs[i].expValid});
         if (vecs[i].chkData) begin
            checkOutput($sformatf("vec%0d_pc", i), pc0, vecs[i].expPc);
            checkOutput($sformatf("vec%0d_inst", i), inst0, vecs[i].expInst);
         end
         applyStimulus(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready);
         tick();
      end

      // Decode stalled: buffer fills with two entries and fetching stops.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
      applyStimulus(1'b1, 1'b1, 32'h1300_0000, 1'b0);
      tick();
      checkOutput("stall_addr4", addr0, 32'h4);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h1300_0004, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      reqSeen = 1'b0;
      pcMoved = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (req0) reqSeen = 1'b1;
         if (pc0 != 32'h0) pcMoved = 1'b1;
         tick();
      end
      checkOutput("stall_req_while_full", {31'b0, reqSeen}, 32'h0);
      checkOutput("stall_head_stable", {31'b0, pcMoved}, 32'h0);
      checkOutput("stall_valid", {31'b0, valid0}, 32'h1);
      checkOutput("stall_head_inst", inst0, 32'h1300_0000);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("drain_pc4", pc0, 32'h4);
      checkOutput("drain_inst4", inst0, 32'h1300_0004);
      checkOutput("resume_req", {31'b0, req0}, 32'h1);
      checkOutput("resume_addr8", addr0, 32'h8);
      tick();
      checkOutput("drain_only_two", {31'b0, valid0}, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h1300_0008, 1'b1);
      tick();
      checkOutput("resume_pc8", pc0, 32'h8);

      // Grant withheld three cycles, then response delayed four cycles.
      doReset();
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("nogrant%0d_req", i), {31'b0, req0}, 32'h1);
         checkOutput($sformatf("nogrant%0d_addr", i), addr0, 32'h0);
         tick();
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
      reqSeen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (req0) reqSeen = 1'b1;
         tick();
      end
      checkOutput("slowrsp_no_req", {31'b0, reqSeen}, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h1300_0000, 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("slowrsp_pc", pc0, 32'h0);
      checkOutput("slowrsp_inst", inst0, 32'h1300_0000);
      checkOutput("slowrsp_next_addr", addr0, 32'h4);

      // PC wraps from the top of the address space.
      doReset();
      gnt1 = 1'b1; ready1 = 1'b1;
      tick();
      checkOutput("wrap_addr_f8", addr1, 32'hFFFF_FFF8);
      tick();
      rv1 = 1'b1; rdata1 = 32'h0000_00A0;
      tick();
      rv1 = 1'b0;
      checkOutput("wrap_addr_fc", addr1, 32'hFFFF_FFFC);
      checkOutput("wrap_pc_f8", pc1, 32'hFFFF_FFF8);
      tick();
      rv1 = 1'b1; rdata1 = 32'h0000_00A1;
      tick();
      rv1 = 1'b0;
      checkOutput("wrap_addr_0", addr1, 32'h0);
      checkOutput("wrap_pc_fc", pc1, 32'hFFFF_FFFC);
      tick();
      rv1 = 1'b1; rdata1 = 32'h0000_00A2;
      tick();
      rv1 = 1'b0;
      checkOutput("wrap_pc_0", pc1, 32'h0);
      checkOutput("wrap_inst_0", inst1, 32'h0000_00A2);

      // Reset during an outstanding fetch; the stale response must be ignored.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
      applyStimulus(1'b1, 1'b1, 32'h1300_0000, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      checkOutput("midrst_valid", {31'b0, valid0}, 32'h0);
      checkOutput("midrst_pc", pc0, 32'h0);
      checkOutput("midrst_inst", inst0, 32'h0);
      checkOutput("midrst_addr", addr0, 32'h0);
      repeat (2) tick();
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
      tick();
      checkOutput("late_rsp_req", {31'b0, req0}, 32'h1);
      checkOutput("late_rsp_ignored", {31'b0, valid0}, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0);
      tick();
      checkOutput("req_rsp_ignored", {31'b0, valid0}, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h1300_0000, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("postrst_pc", pc0, 32'h0);
      checkOutput("postrst_inst", inst0, 32'h1300_0000);

`ifdef IF_REDIRECT_EN
      // Redirect while waiting on the ROM: buffer flushed, in-flight word dropped.
      doReset();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      tick();
      applyStimulus(1'b1, 1'b1, 32'h1300_0000, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      tick();
      redir0 = 1'b1; redirPc0 = 32'h0000_0103;
      tick();
      redir0 = 1'b0;
      checkOutput("redir_flush", {31'b0, valid0}, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h1300_0004, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("redir_drop", {31'b0, valid0}, 32'h0);
      checkOutput("redir_req", {31'b0, req0}, 32'h1);
      checkOutput("redir_addr", addr0, 32'h0000_0100);
      tick();
      applyStimulus(1'b1, 1'b1, 32'h1300_0100, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("redir_pc", pc0, 32'h0000_0100);
      checkOutput("redir_inst", inst0, 32'h1300_0100);
`endif

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
